// File: rtl/calc_key_if.sv
// Keypad / arithmetic-unit bundle seen by the calc_key_entry block.
// Handshake: a key event is the rising edge of btn_press, and the class flags and
// values are sampled in that same cycle. res_valid is a one-cycle strobe that
// qualifies res_bcd. calc_start is a one-cycle request with no ready path; the
// arithmetic unit must accept it and answer later with res_valid. The master
// (scanner, arithmetic unit or bench) drives the inputs; the slave is the entry block.
interface calc_key_if #(
   parameter int DIGITS = 4
);
   logic                  btn_press;
   logic                  is_num;
   logic                  is_op;
   logic                  is_eq;
   logic [3:0]            num_val;
   logic [1:0]            op_val;
   logic                  res_valid;
   logic [4*DIGITS-1:0]   res_bcd;
   logic [4*DIGITS-1:0]   opnd_a;
   logic [4*DIGITS-1:0]   opnd_b;
   logic [1:0]            op_code;
   logic                  calc_start;
   logic [4*DIGITS-1:0]   disp_bcd;
   logic [1:0]            entry_state;

   modport master (
      output btn_press, is_num, is_op, is_eq, num_val, op_val, res_valid, res_bcd,
      input  opnd_a, opnd_b, op_code, calc_start, disp_bcd, entry_state
   );

   modport slave (
      input  btn_press, is_num, is_op, is_eq, num_val, op_val, res_valid, res_bcd,
      output opnd_a, opnd_b, op_code, calc_start, disp_bcd, entry_state
   );
endinterface

// File: rtl/calc_key_entry.sv
// Calculator key-entry block: builds two BCD operands and an operator from key
// events, issues a compute request on '=', and loads the result back as operand A
// so that calculations can be chained. All outputs are registered.
module calc_key_entry #(
   parameter int DIGITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   calc_key_if.slave   bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

   typedef enum logic [1:0] {
      ENTER_A  = 2'd0,
      ENTER_B  = 2'd1,
      WAIT_RES = 2'd2,
      SHOW_RES = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [1:0]      op_q, op_d;
   logic [CW-1:0]   cnt_a_q, cnt_a_d;
   logic [CW-1:0]   cnt_b_q, cnt_b_d;
   logic            entb_q, entb_d;
   logic            start_q, start_d;
   logic [W-1:0]    disp_q, disp_d;
   logic            prev_btn_q;

   logic            key_evt;
   logic            digit_evt;
   logic            op_evt;
   logic            eq_evt;

   // Shift one digit into an operand; leading zeros are not counted and a full
   // operand ignores further digits. Returns {count, value}.
   function automatic logic [CW+W-1:0] enter_digit(input logic [CW-1:0] cnt,
                                                   input logic [W-1:0]  x,
                                                   input logic [3:0]    d);
      logic [CW-1:0] cnt_n;
      logic [W-1:0]  x_n;
      cnt_n = cnt;
      x_n   = x;
      if ((cnt < CNT_FULL) && !((cnt == '0) && (d == 4'd0))) begin
         x_n   = (x << 4) | W'(d);
         cnt_n = cnt + 1'b1;
      end
      return {cnt_n, x_n};
   endfunction

   // Decode key events (rising edge of btn_press, digit > op > eq) and compute next state.
   always_comb begin
      key_evt   = bus.btn_press && !prev_btn_q;
      digit_evt = key_evt && bus.is_num && (bus.num_val <= 4'd9);
      op_evt    = key_evt && !bus.is_num && bus.is_op;
      eq_evt    = key_evt && !bus.is_num && !bus.is_op && bus.is_eq;

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      entb_d  = entb_q;
      start_d = 1'b0;

      case (state_q)
         ENTER_A: begin
            if (digit_evt) begin
               {cnt_a_d, a_d} = enter_digit(cnt_a_q, a_q, bus.num_val);
            end else if (op_evt) begin
               op_d    = bus.op_val;
               b_d     = '0;
               cnt_b_d = '0;
               entb_d  = 1'b0;
               state_d = ENTER_B;
            end
         end
         ENTER_B: begin
            if (digit_evt) begin
               {cnt_b_d, b_d} = enter_digit(cnt_b_q, b_q, bus.num_val);
               entb_d = 1'b1;
            end else if (op_evt) begin
               // The operator may be corrected only until B has its first digit.
               if (!entb_q) op_d = bus.op_val;
            end else if (eq_evt && entb_q) begin
               start_d = 1'b1;
               state_d = WAIT_RES;
            end
         end
         WAIT_RES: begin
            // Keys are dropped here; the result wins even if a key arrives with it.
            if (bus.res_valid) begin
               a_d     = bus.res_bcd;
               cnt_a_d = CNT_FULL;
               state_d = SHOW_RES;
            end
         end
         SHOW_RES: begin
            if (digit_evt) begin
               {cnt_a_d, a_d} = enter_digit('0, '0, bus.num_val);
               state_d = ENTER_A;
            end else if (op_evt) begin
               op_d    = bus.op_val;
               b_d     = '0;
               cnt_b_d = '0;
               entb_d  = 1'b0;
               state_d = ENTER_B;
            end
         end
         default: state_d = ENTER_A;
      endcase

      disp_d = ((state_d == ENTER_B) && entb_d) ? b_d : a_d;
   end

   // State and output registers; the previous-press register resets high so a key
   // held across reset does not register as an event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ENTER_A;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
         entb_q     <= 1'b0;
         start_q    <= 1'b0;
         disp_q     <= '0;
         prev_btn_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
         entb_q     <= entb_d;
         start_q    <= start_d;
         disp_q     <= disp_d;
         prev_btn_q <= bus.btn_press;
      end
   end

   assign bus.opnd_a      = a_q;
   assign bus.opnd_b      = b_q;
   assign bus.op_code     = op_q;
   assign bus.calc_start  = start_q;
   assign bus.disp_bcd    = disp_q;
   assign bus.entry_state = state_q;
endmodule

// File: tb/tb_calc_key_entry.sv
// Bench for calc_key_entry: directed key sequences followed by random keys,
// checked against a decimal-arithmetic reference model through expected queues.
module tb_calc_key_entry;
   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   calc_key_if #(.DIGITS(DIGITS)) bus ();

   calc_key_entry #(.DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic chk  = 1'b0;
   logic done = 1'b0;

   // Snapshot {state, A, B, op, disp} and compute request {A, B, op}.
   logic [3*W+3:0] exp_q[$];
   logic [2*W+1:0] calc_q[$];

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model (decimal values) ----------------
   int m_state, m_a, m_ac, m_b, m_bc, m_op;
   bit m_entb;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic m_reset();
      m_state = 0; m_a = 0; m_ac = 0; m_b = 0; m_bc = 0; m_op = 0; m_entb = 0;
   endtask

   // Append a decimal digit; leading zeros do not count, full operands ignore digits.
   task automatic m_digit(inout int v, inout int c, input int d);
      if (c < DIGITS) begin
         v = v * 10 + d;
         if (!(c == 0 && d == 0)) c = c + 1;
      end
   endtask

   task automatic m_key(input bit n, input bit o, input bit e, input int nv, input int ov);
      bit is_d, is_o, is_e;
      is_d = n && (nv <= 9);
      is_o = !n && o;
      is_e = !n && !o && e;
      case (m_state)
         0: begin
            if (is_d) m_digit(m_a, m_ac, nv);
            else if (is_o) begin
               m_op = ov; m_b = 0; m_bc = 0; m_entb = 0; m_state = 1;
            end
         end
         1: begin
            if (is_d) begin
               m_digit(m_b, m_bc, nv); m_entb = 1;
            end else if (is_o) begin
               if (!m_entb) m_op = ov;
            end else if (is_e && m_entb) begin
               calc_q.push_back({to_bcd(m_a), to_bcd(m_b), 2'(m_op)});
               m_state = 2;
            end
         end
         3: begin
            if (is_d) begin
               m_a = 0; m_ac = 0; m_digit(m_a, m_ac, nv); m_state = 0;
            end else if (is_o) begin
               m_op = ov; m_b = 0; m_bc = 0; m_entb = 0; m_state = 1;
            end
         end
         default: ;
      endcase
   endtask

   task automatic m_res(input int v);
      if (m_state == 2) begin
         m_a = v; m_ac = DIGITS; m_state = 3;
      end
   endtask

   task automatic push_snap();
      logic [W-1:0] disp;
      disp = (m_state == 1 && m_entb) ? to_bcd(m_b) : to_bcd(m_a);
      exp_q.push_back({2'(m_state), to_bcd(m_a), to_bcd(m_b), 2'(m_op), disp});
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.btn_press = 1'b0; bus.is_num = 1'b0; bus.is_op = 1'b0; bus.is_eq = 1'b0;
      bus.num_val = 4'd0; bus.op_val = 2'd0; bus.res_valid = 1'b0; bus.res_bcd = '0;
   endtask

   task automatic strobe_check();
      push_snap();
      chk = 1'b1;
      @(posedge clk); #1;
      chk = 1'b0;
   endtask

   task automatic key(input bit n, input bit o, input bit e, input int nv, input int ov,
                      input bit with_res, input int rv, input int gap);
      @(posedge clk); #1;
      bus.btn_press = 1'b1; bus.is_num = n; bus.is_op = o; bus.is_eq = e;
      bus.num_val = 4'(nv); bus.op_val = 2'(ov);
      bus.res_valid = with_res; bus.res_bcd = to_bcd(rv);
      if (with_res && m_state == 2) m_res(rv);
      else m_key(n, o, e, nv, ov);
      @(posedge clk); #1;
      drive_idle();
      strobe_check();
      repeat (gap) @(posedge clk);
   endtask

   task automatic dig(input int d);  key(1, 0, 0, d, 0, 0, 0, 0); endtask
   task automatic opk(input int o);  key(0, 1, 0, 0, o, 0, 0, 0); endtask
   task automatic eqk();             key(0, 0, 1, 0, 0, 0, 0, 0); endtask

   task automatic res_pulse(input int v);
      @(posedge clk); #1;
      bus.res_valid = 1'b1; bus.res_bcd = to_bcd(v);
      m_res(v);
      @(posedge clk); #1;
      drive_idle();
      strobe_check();
   endtask

   task automatic hold_digit(input int d, input int cycles);
      @(posedge clk); #1;
      bus.btn_press = 1'b1; bus.is_num = 1'b1; bus.num_val = 4'(d);
      m_key(1, 0, 0, d, 0);
      repeat (cycles) @(posedge clk);
      #1;
      drive_idle();
      strobe_check();
   endtask

   task automatic do_reset(input bit hold_btn);
      @(posedge clk); #1;
      rst = 1'b1;
      bus.btn_press = hold_btn; bus.is_num = hold_btn; bus.num_val = 4'd5;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
      strobe_check();
      repeat (3) @(posedge clk);
      #1;
      drive_idle();
      strobe_check();
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      logic [2*W+1:0] ec;
      logic [3*W+3:0] es, as;
      if (bus.calc_start) begin
         n_vec++;
         if (calc_q.size() == 0) begin
            n_err++;
            $display("FAIL calc_start: unexpected pulse a=%h b=%h op=%0d", bus.opnd_a, bus.opnd_b, bus.op_code);
         end else begin
            ec = calc_q.pop_front();
            if ({bus.opnd_a, bus.opnd_b, bus.op_code} !== ec) begin
               n_err++;
               $display("FAIL calc_req: got a=%h b=%h op=%0d, want a=%h b=%h op=%0d",
                        bus.opnd_a, bus.opnd_b, bus.op_code, ec[2*W+1:W+2], ec[W+1:2], ec[1:0]);
            end
         end
      end
      if (chk) begin
         n_vec++;
         as = {bus.entry_state, bus.opnd_a, bus.opnd_b, bus.op_code, bus.disp_bcd};
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL snapshot: no expected entry");
         end else begin
            es = exp_q.pop_front();
            if (as !== es) begin
               n_err++;
               $display("FAIL snapshot @%0t: got st=%0d a=%h b=%h op=%0d disp=%h, want st=%0d a=%h b=%h op=%0d disp=%h",
                        $time, as[3*W+3:3*W+2], as[3*W+1:2*W+2], as[2*W+1:W+2], as[W+1:W], as[W-1:0],
                        es[3*W+3:3*W+2], es[3*W+1:2*W+2], es[2*W+1:W+2], es[W+1:W], es[W-1:0]);
            end
         end
      end
      if (done) begin
         n_vec++;
         if (calc_q.size() != 0) begin
            n_err++;
            $display("FAIL calc_missing: got %0d pending, want 0", calc_q.size());
         end
         n_vec++;
         if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL snap_pending: got %0d pending, want 0", exp_q.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
         $finish;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int r, k, nv, ov;
      bit n, o, e;
      drive_idle();
      m_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      strobe_check();

      // 12 + 34 =, key during wait ignored, result 46, then chained * 2 =
      dig(1); dig(2); opk(0); dig(3); dig(4); eqk();
      dig(5);
      res_pulse(46);
      opk(2); dig(2); eqk();
      res_pulse(92);

      // Leading zeros, then overflow digit
      do_reset(0);
      dig(0); dig(0); dig(7);
      dig(1); dig(2); dig(3); dig(4); dig(5);

      // Operator replacement before B, '=' with B still empty
      do_reset(0);
      dig(9); opk(0); opk(1); dig(0); eqk();
      res_pulse(8);
      do_reset(0);
      dig(9); opk(0); eqk();

      // Held key and key held across reset release
      do_reset(0);
      hold_digit(3, 50);
      do_reset(1);

      // Reset inside WAIT_RES, then a late result
      dig(1); opk(3); dig(2); eqk();
      do_reset(0);
      res_pulse(1234);

      // Result and key in the same cycle
      dig(4); opk(1); dig(1); eqk();
      key(1, 0, 0, 7, 0, 1, 321, 1);
      dig(6);

      // Random keys
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            do_reset(1'($urandom_range(0, 1)));
         end else if (m_state == 2 && r < 45) begin
            if ($urandom_range(0, 1) == 1) res_pulse($urandom_range(0, 9999));
            else key(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 11), $urandom_range(0, 3), 1, $urandom_range(0, 9999),
                     $urandom_range(0, 2));
         end else if (r < 50) begin
            res_pulse($urandom_range(0, 9999));
         end else begin
            k  = $urandom_range(0, 9);
            n  = (k < 5);
            o  = (k == 5 || k == 6) || ($urandom_range(0, 7) == 0);
            e  = (k == 7 || k == 8) || ($urandom_range(0, 7) == 0);
            nv = $urandom_range(0, 11);
            ov = $urandom_range(0, 3);
            key(n, o, e, nv, ov, 0, 0, $urandom_range(0, 2));
         end
      end

      repeat (2) @(posedge clk);
      #1;
      done = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL bench_end: monitor did not finish");
      $fatal(1);
   end
endmodule
